wvb_rd_arbiter: RTL

- Round-robin scheduler that picks which waveform-buffer channel the WVB reader services next.
- Replaces free-running channel cycling with masked, eligibility-driven grants, an ack/done handshake and a readout watchdog.
- Sits between the per-channel header FIFOs' empty flags and the reader's read-controller request/ack path.
- Drives the channel index used by the reader's data, header and strobe mux/demux.

---
 rtl/wvb_rd_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/wvb_rd_arbiter.sv
// rtl/wvb_rd_arbiter.sv - round-robin read-channel arbiter for the WVB reader (optional burst re-grant: WVB_ARB_BURST_EN)
module wvb_rd_arbiter #(
    parameter int N_CHANNELS      = 2,
    parameter int P_TIMEOUT_WIDTH = 16,
    parameter int P_BURST_LEN     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_CHANNELS-1:0]      hdr_empty,
    input  logic [N_CHANNELS-1:0]      chan_mask,
    input  logic [P_TIMEOUT_WIDTH-1:0] timeout_cycles,
    input  logic                       grant_ack,
    input  logic                       rd_done,
    output logic                       grant_valid,
    output logic [4:0]                 grant_idx,
    output logic [N_CHANNELS-1:0]      grant_onehot,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [4:0]                 timeout_chan
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_BUSY,
        S_HOLD
    } state_t;

    localparam logic [4:0]                 LAST_INIT = 5'(N_CHANNELS - 1);
    localparam logic [P_TIMEOUT_WIDTH-1:0] WD_ONE    = 1;

    state_t                       state;
    logic [N_CHANNELS-1:0]        eligible_q;
    logic [4:0]                   last_idx;
    logic [P_TIMEOUT_WIDTH-1:0]   wd_cnt;
    logic [N_CHANNELS-1:0]        gnt_dec;
    logic                         gnt_elig;
    logic                         rr_found;
    logic [4:0]                   rr_idx;

`ifdef WVB_ARB_BURST_EN
    localparam logic [7:0] BURST_MAX = 8'(P_BURST_LEN);

    logic [7:0]            burst_cnt;
    logic                  burst_ok;
    logic [N_CHANNELS-1:0] last_dec;
    logic                  last_elig;
    logic                  burst_hit;

    // Re-grant the channel just served while its burst allowance lasts
    always_comb begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            last_dec[i] = (last_idx == 5'(i));
        end
        last_elig = |(eligible_q & last_dec);
        burst_hit = burst_ok && last_elig && (burst_cnt < BURST_MAX);
    end
`endif

    // Decode the held grant index; eligibility of the offered channel gates withdrawal
    always_comb begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            gnt_dec[i]      = (grant_idx == 5'(i));
            grant_onehot[i] = grant_valid && (grant_idx == 5'(i));
        end
        gnt_elig = |(eligible_q & gnt_dec);
    end

    // First eligible channel after last_idx: above it first, then wrap to the lowest
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = 5'd0;
        for (int j = 0; j < N_CHANNELS; j++) begin
            if (!rr_found && eligible_q[j] && (5'(j) > last_idx)) begin
                rr_found = 1'b1;
                rr_idx   = 5'(j);
            end
        end
        for (int j = 0; j < N_CHANNELS; j++) begin
            if (!rr_found && eligible_q[j]) begin
                rr_found = 1'b1;
                rr_idx   = 5'(j);
            end
        end
    end

    // Arbiter FSM: idle -> grant -> busy (watchdog) -> hold turnaround -> idle
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state       <= S_IDLE;
            eligible_q  <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= 5'd0;
            busy        <= 1'b0;
            last_idx    <= LAST_INIT;
            wd_cnt      <= '0;
`ifdef WVB_ARB_BURST_EN
            burst_cnt   <= 8'd0;
            burst_ok    <= 1'b0;
`endif
            if (rst) begin
                timeout_err  <= 1'b0;
                timeout_chan <= 5'd0;
            end
        end else begin
            eligible_q <= ~hdr_empty & chan_mask;
            case (state)
                S_IDLE: begin
`ifdef WVB_ARB_BURST_EN
                    if (burst_hit) begin
                        grant_idx   <= last_idx;
                        grant_valid <= 1'b1;
                        state       <= S_GRANT;
                    end else
`endif
                    if (rr_found) begin
                        grant_idx   <= rr_idx;
                        grant_valid <= 1'b1;
                        state       <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (grant_ack) begin
                        grant_valid <= 1'b0;
                        busy        <= 1'b1;
                        last_idx    <= grant_idx;
                        wd_cnt      <= '0;
                        state       <= S_BUSY;
`ifdef WVB_ARB_BURST_EN
                        burst_ok    <= 1'b0;
                        if ((grant_idx == last_idx) && (burst_cnt != 8'd0)) begin
                            burst_cnt <= burst_cnt + 8'd1;
                        end else begin
                            burst_cnt <= 8'd1;
                        end
`endif
                    end else if (!gnt_elig) begin
                        grant_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (rd_done) begin
                        busy  <= 1'b0;
                        state <= S_HOLD;
`ifdef WVB_ARB_BURST_EN
                        burst_ok <= 1'b1;
`endif
                    end else if ((timeout_cycles != '0) &&
                                 (wd_cnt == timeout_cycles - WD_ONE)) begin
                        timeout_err  <= 1'b1;
                        timeout_chan <= grant_idx;
                        busy         <= 1'b0;
                        state        <= S_HOLD;
                    end else if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + WD_ONE;
                    end
                end
                S_HOLD: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
